// File: rtl/score_display_scan_if.sv
// Score-in / display-out bundle between the score counter and the 7-segment scan driver.
interface score_display_scan_if;
  localparam int unsigned SCORE_W = 12;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned DIG_W   = 3;

  logic [SCORE_W-1:0] score_data;
  logic               blank_lz;
  logic [SEG_W-1:0]   seg_n;
  logic [DIG_W-1:0]   dig_n;
  logic               frame_done;
  logic               err;

  modport master (
    output score_data, blank_lz,
    input  seg_n, dig_n, frame_done, err
  );

  modport slave (
    input  score_data, blank_lz,
    output seg_n, dig_n, frame_done, err
  );
endinterface

// File: rtl/score_display_scan.sv
// Multiplexed 3-digit active-low 7-segment scan of a packed-BCD score, with one
// score snapshot per frame, optional leading-zero blanking and invalid-BCD flag.
module score_display_scan #(
  parameter int unsigned SCAN_DIV = 12000
) (
  input  logic               clk,
  input  logic               rst,
  score_display_scan_if.slave bus
);

  localparam int unsigned PCNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SCORE_W = 12;
  localparam int unsigned NIB_W   = 4;

  typedef enum logic [1:0] {
    IDX_UNITS = 2'd0,
    IDX_TENS  = 2'd1,
    IDX_HUNDS = 2'd2
  } idx_e;

  idx_e               idx_q, idx_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [SCORE_W-1:0] snap_q, snap_d;
  logic [7:0]         seg_n_q, seg_n_d;
  logic [2:0]         dig_n_q, dig_n_d;
  logic               err_q, err_d;
  logic               frame_done_q, frame_done_d;
  logic               started_q, started_d;

  logic               tick_c;
  logic [NIB_W-1:0]   nib_c;
  logic               blank_c;

  function automatic logic [7:0] seg_decode(input logic [NIB_W-1:0] nib);
    case (nib)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hBF;
    endcase
  endfunction

  function automatic logic nib_bad(input logic [NIB_W-1:0] nib);
    nib_bad = (nib > NIB_W'(9));
  endfunction

  assign tick_c = (pcnt_q == PCNT_W'(SCAN_DIV - 1));

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= IDX_HUNDS;
      pcnt_q       <= '0;
      snap_q       <= '0;
      seg_n_q      <= 8'hFF;
      dig_n_q      <= 3'b111;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      pcnt_q       <= pcnt_d;
      snap_q       <= snap_d;
      seg_n_q      <= seg_n_d;
      dig_n_q      <= dig_n_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      started_q    <= started_d;
    end
  end

  // Digit sequencing, snapshot and segment decode for the next slot
  always_comb begin
    idx_d        = idx_q;
    pcnt_d       = pcnt_q + PCNT_W'(1);
    snap_d       = snap_q;
    seg_n_d      = seg_n_q;
    dig_n_d      = dig_n_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    started_d    = started_q;
    nib_c        = '0;
    blank_c      = 1'b0;

    if (tick_c) begin
      pcnt_d    = '0;
      started_d = 1'b1;
      // The very first wrap after reset closes no real frame
      frame_done_d = started_q && (idx_q == IDX_HUNDS);

      case (idx_q)
        IDX_UNITS: idx_d = IDX_TENS;
        IDX_TENS:  idx_d = IDX_HUNDS;
        default:   idx_d = IDX_UNITS;
      endcase

      case (idx_d)
        IDX_UNITS: begin
          nib_c   = bus.score_data[3:0];
          snap_d  = bus.score_data;
          err_d   = nib_bad(bus.score_data[11:8]) || nib_bad(bus.score_data[7:4]) ||
                    nib_bad(bus.score_data[3:0]);
          dig_n_d = 3'b110;
        end
        IDX_TENS: begin
          nib_c   = snap_q[7:4];
          blank_c = bus.blank_lz && (snap_q[11:8] == 4'd0) && (snap_q[7:4] == 4'd0);
          dig_n_d = 3'b101;
        end
        default: begin
          nib_c   = snap_q[11:8];
          blank_c = bus.blank_lz && (snap_q[11:8] == 4'd0);
          dig_n_d = 3'b011;
        end
      endcase

      seg_n_d = blank_c ? 8'hFF : seg_decode(nib_c);
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.dig_n      = dig_n_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_done_q;

endmodule
